led_pong_core: RTL and testbench
================================

Name: led_pong_core

Overview:
- Parametrised game engine for the LED ping-pong game; successor to the fixed 16-LED, single-speed game logic.
- Generalises LED count, hit window, score limit and game tick rate.
- Adds progressive ball speed-up, foul detection (early hit), loser-serves rule and a game-over state.
- Sits between debounced switch/button inputs and the LED bar and seven-segment score driver in the top module.

Parameters:
N_LEDS, 16, number of LEDs in the ball track (>=4); bit 0 = right end, bit N_LEDS-1 = left end
TICK_DIV, 625000, clk cycles per ball step at speed level 0
MAX_SPEED, 3, highest speed level; period = TICK_DIV >> level; requires TICK_DIV >= 2**MAX_SPEED
HIT_WIN, 2, number of LEDs at each end where a hit is accepted (1..N_LEDS/2)
SCORE_MAX, 9, points needed to win (1..15)
PAUSE_TICKS, 4, level-0 ticks spent in POINT state

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  pulse; starts or restarts a game
hit_l  input  1  left player switch (level); rising edge = hit
hit_r  input  1  right player switch (level); rising edge = hit
led  output  N_LEDS  ball position, one-hot during play
score_l  output  4  left player score
score_r  output  4  right player score
speed  output  $clog2(MAX_SPEED+1)  current speed level
game_over  output  1  high in OVER
winner  output  1  valid when game_over: 1 = left, 0 = right

Behaviour:
- All outputs registered. On rst=1 at a clk edge: state IDLE, led=0, scores=0, speed=0, game_over=0, winner=0, pos=0, server=right, tick counter=0. Reset mid-rally behaves identically.
- Edge detect: hit_l/hit_r sampled into one register each; rise = in & ~prev. prev registers clear on reset. A switch held high produces only one rise.
- Tick generator:
  - Counter of width $clog2(TICK_DIV) counts 0..(TICK_DIV>>speed)-1.
  - tick = one-cycle pulse at terminal count.
  - Counter clears on every state transition and on every accepted hit.
- States:
  - IDLE: led=0. start -> SERVE; scores cleared, server=right.
  - SERVE: pos = 0 if server is right, N_LEDS-1 if server is left. led = one-hot(pos). Server's rise -> MOVE away from server. Ticks and all other inputs ignored.
  - MOVE_L (pos increasing): on tick pos+1. At pos=N_LEDS-1, a tick with no hit = miss.
  - MOVE_R (pos decreasing): on tick pos-1. At pos=0, a tick with no hit = miss.
  - POINT: led = all ones. Held for PAUSE_TICKS ticks at level-0 period. Then:
    - scorer's score == SCORE_MAX -> OVER.
    - otherwise -> SERVE, server = loser of the point.
  - OVER: game_over=1, winner set. led = winner's half lit (upper N_LEDS/2 bits for left, lower for right). start -> SERVE; scores=0, server=right, game_over=0.
- Hits while moving:
  - Receiving player's rise with pos inside its window (left: pos >= N_LEDS-HIT_WIN; right: pos <= HIT_WIN-1): direction reverses, pos unchanged, speed = min(speed+1, MAX_SPEED), tick counter cleared.
  - Receiving player's rise outside the window: foul; point to opponent.
  - Rise from the player the ball is moving away from: ignored.
- Point scoring: scorer's score +1 on POINT entry. speed reset to 0.
- Simultaneous events:
  - A hit and a tick in the same cycle: the hit is evaluated against the pre-tick pos, and the hit wins.
  - hit_l and hit_r rise together: only the receiving player's rise counts.
  - start is ignored outside IDLE and OVER.

Test Plan:
Params N_LEDS=8, TICK_DIV=8, MAX_SPEED=2, HIT_WIN=2, SCORE_MAX=2, PAUSE_TICKS=2.
1. rst, then start, then hit_r rise -> led=0x01 in SERVE; after the hit led steps 0x02, 0x04 ... 0x80, one step per 8 clk; speed=0.
2. Ball at pos 6 moving left, hit_l rise -> direction reverses; speed=1; led 0x40 -> 0x20 after 4 clk.
3. Ball at pos 7, no hit, tick -> score_r=1; led=0xFF for 16 clk; then SERVE with led=0x80 (left serves); speed=0.
4. Ball at pos 3 moving left, hit_l rise -> foul; score_r increments; hit_r rise in the same cycle has no effect.
5. Rally with 3 successful hits -> speed saturates at 2 (period 2 clk); hit and tick coincident at pos 7 -> return accepted, no point.
6. score_r reaches 2 -> game_over=1, winner=0, led=0x0F; rst mid-rally -> all outputs 0 next cycle; start from OVER -> scores 0, led=0x01.

Source files
------------

// File: rtl/led_pong_core_if.sv
// ----------------------------------------------------------------------------
// led_pong_core_if
// Groups the player/control inputs and the display outputs of the pong engine.
//
// Signals:
//   start      - pulse; starts or restarts a game           (master -> slave)
//   hit_l      - left player switch level, rising edge = hit (master -> slave)
//   hit_r      - right player switch level, rising edge = hit(master -> slave)
//   led        - ball track, bit 0 = right end               (slave -> master)
//   score_l    - left player score                           (slave -> master)
//   score_r    - right player score                          (slave -> master)
//   speed      - current ball speed level                    (slave -> master)
//   game_over  - high while the game is finished             (slave -> master)
//   winner     - 1 = left won, 0 = right won                 (slave -> master)
//
// Modports:
//   master - the side that drives the switches and reads the display
//   slave  - the game engine itself
// ----------------------------------------------------------------------------
interface led_pong_core_if #(
    parameter int N_LEDS    = 16,
    parameter int MAX_SPEED = 3
);

    localparam int SPEED_W = (MAX_SPEED > 0) ? $clog2(MAX_SPEED + 1) : 1;

    logic                 start;
    logic                 hit_l;
    logic                 hit_r;
    logic [N_LEDS-1:0]    led;
    logic [3:0]           score_l;
    logic [3:0]           score_r;
    logic [SPEED_W-1:0]   speed;
    logic                 game_over;
    logic                 winner;

    modport master (
        output start, hit_l, hit_r,
        input  led, score_l, score_r, speed, game_over, winner
    );

    modport slave (
        input  start, hit_l, hit_r,
        output led, score_l, score_r, speed, game_over, winner
    );

endinterface

// File: rtl/led_pong_core.sv
// ----------------------------------------------------------------------------
// led_pong_core
// Game engine for the LED ping-pong game. A ball runs along an LED track and
// the players return it by pressing their switch while the ball is inside
// their hit window near their end. Every successful return speeds the ball up
// one level. Missing the ball or hitting too early gives the point to the
// opponent. The loser of a point serves next and the first player to reach
// SCORE_MAX wins.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - led_pong_core_if.slave
//            in : start, hit_l, hit_r
//            out: led, score_l, score_r, speed, game_over, winner
//
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module led_pong_core #(
    parameter int N_LEDS      = 16,
    parameter int TICK_DIV    = 625000,
    parameter int MAX_SPEED   = 3,
    parameter int HIT_WIN     = 2,
    parameter int SCORE_MAX   = 9,
    parameter int PAUSE_TICKS = 4
) (
    input  logic            clk,
    input  logic            rst,
    led_pong_core_if.slave  bus
);

    localparam int POS_W   = $clog2(N_LEDS);
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SPD_W   = (MAX_SPEED > 0) ? $clog2(MAX_SPEED + 1) : 1;
    localparam int PAUSE_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SERVE  = 3'd1;
    localparam logic [2:0] ST_MOVE_L = 3'd2;
    localparam logic [2:0] ST_MOVE_R = 3'd3;
    localparam logic [2:0] ST_POINT  = 3'd4;
    localparam logic [2:0] ST_OVER   = 3'd5;

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]   POS_LWIN   = POS_W'(N_LEDS - HIT_WIN);
    localparam logic [POS_W-1:0]   POS_RWIN   = POS_W'(HIT_WIN - 1);
    localparam logic [SPD_W-1:0]   SPD_MAX    = SPD_W'(MAX_SPEED);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);
    localparam logic [3:0]         SCORE_WIN  = 4'(SCORE_MAX);

    localparam logic [N_LEDS-1:0] LED_ONE   = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] LED_ALL   = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0] LED_LEFT  = {{(N_LEDS/2){1'b1}}, {(N_LEDS-N_LEDS/2){1'b0}}};
    localparam logic [N_LEDS-1:0] LED_RIGHT = {{(N_LEDS-N_LEDS/2){1'b0}}, {(N_LEDS/2){1'b1}}};

    // Registered state
    logic [2:0]         r_state;
    logic [POS_W-1:0]   r_pos;
    logic               r_server;   // 1 = left serves, 0 = right serves
    logic               r_scorer;   // 1 = left scored the current point
    logic [SPD_W-1:0]   r_speed;
    logic [3:0]         r_score_l;
    logic [3:0]         r_score_r;
    logic               r_winner;
    logic               r_game_over;
    logic [N_LEDS-1:0]  r_led;
    logic [CNT_W-1:0]   r_cnt;
    logic [PAUSE_W-1:0] r_pause;
    logic               r_hit_l_prev;
    logic               r_hit_r_prev;

    // Next-state values
    logic [2:0]         w_state_n;
    logic [POS_W-1:0]   w_pos_n;
    logic               w_server_n;
    logic               w_scorer_n;
    logic [SPD_W-1:0]   w_speed_n;
    logic [3:0]         w_score_l_n;
    logic [3:0]         w_score_r_n;
    logic               w_winner_n;
    logic [PAUSE_W-1:0] w_pause_n;
    logic [N_LEDS-1:0]  w_led_n;

    logic               w_rise_l;
    logic               w_rise_r;
    logic [CNT_W-1:0]   w_term;
    logic               w_tick;
    logic               w_hit_ok;
    logic               w_point;
    logic               w_point_l;
    logic               w_cnt_clr;

    // A switch that is held down only counts once, on the cycle it goes high.
    assign w_rise_l = bus.hit_l & ~r_hit_l_prev;
    assign w_rise_r = bus.hit_r & ~r_hit_r_prev;

    // Step period halves with each speed level. The terminal count is taken
    // modulo the counter width, so a power-of-two period still wraps cleanly.
    assign w_term = CNT_W'((TICK_DIV >> r_speed) - 1);
    assign w_tick = (r_cnt == w_term);

    // Game FSM and all datapath next values. A hit is always checked before
    // the tick so a return on the same cycle as a step uses the old position
    // and wins over a miss. Point awards from any state are collected into
    // w_point and applied once after the case.
    always_comb begin
        w_state_n   = r_state;
        w_pos_n     = r_pos;
        w_server_n  = r_server;
        w_scorer_n  = r_scorer;
        w_speed_n   = r_speed;
        w_score_l_n = r_score_l;
        w_score_r_n = r_score_r;
        w_winner_n  = r_winner;
        w_pause_n   = r_pause;
        w_hit_ok    = 1'b0;
        w_point     = 1'b0;
        w_point_l   = 1'b0;
        w_led_n     = '0;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    w_state_n   = ST_SERVE;
                    w_score_l_n = 4'd0;
                    w_score_r_n = 4'd0;
                    w_server_n  = 1'b0;
                    w_pos_n     = '0;
                end
            end

            ST_SERVE: begin
                if (r_server ? w_rise_l : w_rise_r) begin
                    w_state_n = r_server ? ST_MOVE_R : ST_MOVE_L;
                end
            end

            ST_MOVE_L: begin
                if (w_rise_l) begin
                    if (r_pos >= POS_LWIN) begin
                        w_state_n = ST_MOVE_R;
                        w_hit_ok  = 1'b1;
                    end else begin
                        w_point   = 1'b1;
                        w_point_l = 1'b0;
                    end
                end else if (w_tick) begin
                    if (r_pos == POS_LAST) begin
                        w_point   = 1'b1;
                        w_point_l = 1'b0;
                    end else begin
                        w_pos_n = r_pos + POS_W'(1);
                    end
                end
            end

            ST_MOVE_R: begin
                if (w_rise_r) begin
                    if (r_pos <= POS_RWIN) begin
                        w_state_n = ST_MOVE_L;
                        w_hit_ok  = 1'b1;
                    end else begin
                        w_point   = 1'b1;
                        w_point_l = 1'b1;
                    end
                end else if (w_tick) begin
                    if (r_pos == '0) begin
                        w_point   = 1'b1;
                        w_point_l = 1'b1;
                    end else begin
                        w_pos_n = r_pos - POS_W'(1);
                    end
                end
            end

            ST_POINT: begin
                if (w_tick) begin
                    if (r_pause == PAUSE_LAST) begin
                        w_pause_n = '0;
                        if (r_scorer ? (r_score_l == SCORE_WIN) : (r_score_r == SCORE_WIN)) begin
                            w_state_n  = ST_OVER;
                            w_winner_n = r_scorer;
                        end else begin
                            w_state_n  = ST_SERVE;
                            w_server_n = ~r_scorer;
                            w_pos_n    = r_scorer ? '0 : POS_LAST;
                        end
                    end else begin
                        w_pause_n = r_pause + PAUSE_W'(1);
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_hit_ok) begin
            w_speed_n = (r_speed == SPD_MAX) ? r_speed : r_speed + SPD_W'(1);
        end

        if (w_point) begin
            w_state_n  = ST_POINT;
            w_scorer_n = w_point_l;
            w_speed_n  = '0;
            w_pause_n  = '0;
            if (w_point_l) begin
                w_score_l_n = r_score_l + 4'd1;
            end else begin
                w_score_r_n = r_score_r + 4'd1;
            end
        end

        case (w_state_n)
            ST_SERVE, ST_MOVE_L, ST_MOVE_R: w_led_n = LED_ONE << w_pos_n;
            ST_POINT:                       w_led_n = LED_ALL;
            ST_OVER:                        w_led_n = w_winner_n ? LED_LEFT : LED_RIGHT;
            default:                        w_led_n = '0;
        endcase
    end

    // Step counter restarts on every state change and every good return so
    // the first step after an event always takes a full period.
    assign w_cnt_clr = w_hit_ok || (w_state_n != r_state);

    // Tick counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Game state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pos        <= '0;
            r_server     <= 1'b0;
            r_scorer     <= 1'b0;
            r_speed      <= '0;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_winner     <= 1'b0;
            r_game_over  <= 1'b0;
            r_led        <= '0;
            r_pause      <= '0;
            r_hit_l_prev <= 1'b0;
            r_hit_r_prev <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pos        <= w_pos_n;
            r_server     <= w_server_n;
            r_scorer     <= w_scorer_n;
            r_speed      <= w_speed_n;
            r_score_l    <= w_score_l_n;
            r_score_r    <= w_score_r_n;
            r_winner     <= w_winner_n;
            r_game_over  <= (w_state_n == ST_OVER);
            r_led        <= w_led_n;
            r_pause      <= w_pause_n;
            r_hit_l_prev <= bus.hit_l;
            r_hit_r_prev <= bus.hit_r;
        end
    end

    assign bus.led       = r_led;
    assign bus.score_l   = r_score_l;
    assign bus.score_r   = r_score_r;
    assign bus.speed     = r_speed;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;

endmodule

// File: tb/tb_led_pong_core.sv
// ----------------------------------------------------------------------------
// tb_led_pong_core
// Directed bench for led_pong_core with a small configuration: 8 LEDs,
// 8 clocks per step at level 0, max speed 2, hit window 2, two points to win,
// two pause ticks. Expected outputs are queued against an absolute cycle
// number; a monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_led_pong_core;

    localparam int N_LEDS      = 8;
    localparam int TICK_DIV    = 8;
    localparam int MAX_SPEED   = 2;
    localparam int HIT_WIN     = 2;
    localparam int SCORE_MAX   = 2;
    localparam int PAUSE_TICKS = 2;

    // Cycle on which the first serve is hit; rally timing is relative to it.
    localparam int B = 4;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] led;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] spd;
        logic       go;
        logic       win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    exp_t sbQ[$];

    led_pong_core_if #(.N_LEDS(N_LEDS), .MAX_SPEED(MAX_SPEED)) bus ();

    led_pong_core #(
        .N_LEDS     (N_LEDS),
        .TICK_DIV   (TICK_DIV),
        .MAX_SPEED  (MAX_SPEED),
        .HIT_WIN    (HIT_WIN),
        .SCORE_MAX  (SCORE_MAX),
        .PAUSE_TICKS(PAUSE_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Absolute cycle count: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Advance until the given rising edge has happened, then settle 1 ns
    task automatic applyStimulus(input int untilCyc);
        while (cyc < untilCyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the expected outputs for the current cycle
    task automatic checkOutput(input string name, input logic [7:0] led,
                               input logic [3:0] sl, input logic [3:0] sr,
                               input logic [1:0] spd, input logic go,
                               input logic win);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.led  = led;
        e.sl   = sl;
        e.sr   = sr;
        e.spd  = spd;
        e.go   = go;
        e.win  = win;
        sbQ.push_back(e);
    endtask

    // Monitor: compare every entry due by this cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            e = sbQ.pop_front();
            nChecks++;
            if (e.cyc != cyc ||
                {bus.led, bus.score_l, bus.score_r, bus.speed, bus.game_over, bus.winner} !==
                {e.led, e.sl, e.sr, e.spd, e.go, e.win}) begin
                nFails++;
                $display("[TB] FAIL %s @%0d: got led=%h sl=%0d sr=%0d spd=%0d go=%b win=%b, want led=%h sl=%0d sr=%0d spd=%0d go=%b win=%b",
                         e.name, cyc, bus.led, bus.score_l, bus.score_r, bus.speed,
                         bus.game_over, bus.winner, e.led, e.sl, e.sr, e.spd, e.go, e.win);
            end
        end
    end

    // Directed game script
    initial begin
        bus.start = 1'b0;
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;

        applyStimulus(2);
        checkOutput("reset", 8'h00, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.start = 1'b1;

        applyStimulus(3);
        checkOutput("serve_right", 8'h01, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.hit_r = 1'b1;

        // Right serves, ball moves left at 8 clocks per step
        applyStimulus(B + 0);
        checkOutput("launch", 8'h01, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 7);
        checkOutput("hold_pos0", 8'h01, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 8);
        checkOutput("step1", 8'h02, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        nChecks++;
        if (bus.led !== 8'h02) begin
            nFails++;
            $display("[TB] FAIL direct step1: led=%h want 02", bus.led);
        end
        applyStimulus(B + 16);
        checkOutput("step2", 8'h04, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.start = 1'b1;
        applyStimulus(B + 17);
        bus.start = 1'b0;
        applyStimulus(B + 24);
        checkOutput("start_ignored", 8'h08, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);

        // Left returns at pos 6, speed 1 (4 clocks per step)
        applyStimulus(B + 48);
        checkOutput("pos6", 8'h40, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.hit_l = 1'b1;
        applyStimulus(B + 49);
        checkOutput("return_left", 8'h40, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0);
        nChecks++;
        if (bus.speed !== 2'd1) begin
            nFails++;
            $display("[TB] FAIL direct return_left: speed=%0d want 1", bus.speed);
        end
        bus.hit_r = 1'b0;
        applyStimulus(B + 52);
        checkOutput("wait4", 8'h40, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0);
        applyStimulus(B + 53);
        checkOutput("step_right", 8'h20, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0);
        bus.hit_l = 1'b0;

        // Right returns at pos 1, speed 2 (2 clocks per step)
        applyStimulus(B + 69);
        checkOutput("pos1", 8'h02, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0);
        bus.hit_r = 1'b1;
        applyStimulus(B + 70);
        checkOutput("return_right", 8'h02, 4'd0, 4'd0, 2'd2, 1'b0, 1'b0);
        applyStimulus(B + 72);
        checkOutput("fast_step", 8'h04, 4'd0, 4'd0, 2'd2, 1'b0, 1'b0);
        bus.hit_r = 1'b0;

        // Left hits on the same cycle as the miss tick at pos 7: return wins
        applyStimulus(B + 82);
        checkOutput("pos7", 8'h80, 4'd0, 4'd0, 2'd2, 1'b0, 1'b0);
        applyStimulus(B + 83);
        bus.hit_l = 1'b1;
        applyStimulus(B + 84);
        checkOutput("hit_tick", 8'h80, 4'd0, 4'd0, 2'd2, 1'b0, 1'b0);
        applyStimulus(B + 86);
        checkOutput("saturated_step", 8'h40, 4'd0, 4'd0, 2'd2, 1'b0, 1'b0);
        bus.hit_l = 1'b0;

        // Right misses at pos 0: point to left, pause 16 clocks, right serves
        applyStimulus(B + 100);
        checkOutput("miss_right", 8'hFF, 4'd1, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 115);
        checkOutput("pause_end", 8'hFF, 4'd1, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 116);
        checkOutput("right_serves", 8'h01, 4'd1, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.hit_r = 1'b1;
        applyStimulus(B + 117);
        checkOutput("launch2", 8'h01, 4'd1, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.hit_r = 1'b0;

        // Left fouls at pos 3 while right also rises: point to right only
        applyStimulus(B + 141);
        checkOutput("pos3", 8'h08, 4'd1, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.hit_l = 1'b1;
        bus.hit_r = 1'b1;
        applyStimulus(B + 142);
        checkOutput("foul_left", 8'hFF, 4'd1, 4'd1, 2'd0, 1'b0, 1'b0);
        nChecks++;
        if (bus.score_r !== 4'd1) begin
            nFails++;
            $display("[TB] FAIL direct foul_left: score_r=%0d want 1", bus.score_r);
        end
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;
        applyStimulus(B + 157);
        checkOutput("pause2", 8'hFF, 4'd1, 4'd1, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 158);
        checkOutput("left_serves", 8'h80, 4'd1, 4'd1, 2'd0, 1'b0, 1'b0);
        bus.hit_l = 1'b1;
        applyStimulus(B + 159);
        checkOutput("launch_left", 8'h80, 4'd1, 4'd1, 2'd0, 1'b0, 1'b0);

        // hit_l stays high: right returns at pos 1, no second left rise
        applyStimulus(B + 207);
        checkOutput("pos1b", 8'h02, 4'd1, 4'd1, 2'd0, 1'b0, 1'b0);
        bus.hit_r = 1'b1;
        applyStimulus(B + 208);
        checkOutput("return_right2", 8'h02, 4'd1, 4'd1, 2'd1, 1'b0, 1'b0);
        applyStimulus(B + 212);
        checkOutput("held_no_rise", 8'h04, 4'd1, 4'd1, 2'd1, 1'b0, 1'b0);
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;

        // Second left foul gives right the match
        applyStimulus(B + 216);
        checkOutput("pos3b", 8'h08, 4'd1, 4'd1, 2'd1, 1'b0, 1'b0);
        bus.hit_l = 1'b1;
        applyStimulus(B + 217);
        checkOutput("foul_left2", 8'hFF, 4'd1, 4'd2, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 232);
        checkOutput("pause3", 8'hFF, 4'd1, 4'd2, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 233);
        checkOutput("game_over", 8'h0F, 4'd1, 4'd2, 2'd0, 1'b1, 1'b0);
        nChecks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL direct game_over: go=%b win=%b want go=1 win=0", bus.game_over, bus.winner);
        end
        bus.hit_l = 1'b0;
        bus.start = 1'b1;

        // Restart from OVER, then reset in the middle of the rally
        applyStimulus(B + 234);
        checkOutput("restart", 8'h01, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.hit_r = 1'b1;
        applyStimulus(B + 235);
        checkOutput("launch3", 8'h01, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(B + 240);
        checkOutput("pre_reset", 8'h01, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(B + 241);
        checkOutput("mid_reset", 8'h00, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        nChecks++;
        if (bus.led !== 8'h00) begin
            nFails++;
            $display("[TB] FAIL direct mid_reset: led=%h want 00", bus.led);
        end
        rst = 1'b0;
        applyStimulus(B + 243);
        checkOutput("idle_hit_ignored", 8'h00, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        bus.hit_r = 1'b0;

        applyStimulus(B + 245);
        @(negedge clk);
        #1;
        while (sbQ.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: expectation for cycle %0d never compared", sbQ[0].name, sbQ[0].cyc);
            void'(sbQ.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
